// File: rtl/cordic_arbiter.sv
// cordic_arbiter: round-robin sharing of one fixed-latency CORDIC core with per-requester credit and tag-routed responses.
module cordic_arbiter #(
    parameter int N_REQ        = 4,
    parameter int WIDTH        = 16,
    parameter int TAG_W        = 4,
    parameter int CORE_LATENCY = 20
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [N_REQ-1:0]                 req_valid,
    input  logic [N_REQ-1:0][2*WIDTH-1:0]    req_data,
    output logic [N_REQ-1:0]                 req_ready,
    output logic [N_REQ-1:0]                 rsp_valid,
    output logic [N_REQ-1:0][2*WIDTH-1:0]    rsp_data,
    input  logic [N_REQ-1:0]                 rsp_ready,
    output logic                             core_tvalid,
    output logic [2*WIDTH-1:0]               core_tdata,
    output logic [TAG_W-1:0]                 core_tuser,
    input  logic                             core_dout_tvalid,
    input  logic [2*WIDTH-1:0]               core_dout_tdata,
    input  logic [TAG_W-1:0]                 core_dout_tuser,
    output logic [$clog2(N_REQ+1)-1:0]       in_flight,
    output logic                             err
);
    localparam int PW = $clog2(N_REQ);
    localparam int CW = $clog2(CORE_LATENCY + 1);
    localparam int IW = $clog2(N_REQ + 1);
    typedef enum logic {DRAIN, RUN} state_t;
    state_t           state, state_n;
    logic [CW-1:0]    cnt;
    logic [PW-1:0]    ptr, gidx, tidx;
    logic [N_REQ-1:0] busy, busy_n, elig, grant, consume, rsp_set;
    logic             tag_ok, beat_ok, beat_err;
    function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] p, input int i);
        int s;
        s = int'(p) + 1 + i;
        return PW'(s >= N_REQ ? s - N_REQ : s);
    endfunction
    function automatic logic [IW-1:0] popcount(input logic [N_REQ-1:0] v);
        logic [IW-1:0] c;
        c = '0;
        for (int i = 0; i < N_REQ; i++) c = c + IW'(v[i]);
        return c;
    endfunction
    always_comb begin
        state_n = (state == DRAIN && cnt == '0) ? RUN : state;
        elig    = (state == RUN) ? req_valid & ~busy : '0;
        gidx    = '0;
        for (int i = N_REQ - 1; i >= 0; i--) gidx = elig[rr_idx(ptr, i)] ? rr_idx(ptr, i) : gidx;
        grant       = '0;
        grant[gidx] = |elig;
        tidx     = PW'(core_dout_tuser);
        tag_ok   = {1'b0, core_dout_tuser} < (TAG_W + 1)'(N_REQ);
        beat_ok  = tag_ok && busy[tidx] && !rsp_valid[tidx];
        beat_err = state == RUN && core_dout_tvalid && !beat_ok;
        rsp_set       = '0;
        rsp_set[tidx] = state == RUN && core_dout_tvalid && beat_ok;
        consume = rsp_valid & rsp_ready;
        busy_n  = (busy | grant) & ~consume;
    end
    assign req_ready = grant;
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= DRAIN;
            cnt         <= CW'(CORE_LATENCY);
            ptr         <= PW'(N_REQ - 1);
            busy        <= '0;
            in_flight   <= '0;
            err         <= 1'b0;
            rsp_valid   <= '0;
            rsp_data    <= '0;
            core_tvalid <= 1'b0;
            core_tdata  <= '0;
            core_tuser  <= '0;
        end else begin
            state       <= state_n;
            cnt         <= (state == DRAIN && cnt != '0) ? cnt - CW'(1) : cnt;
            ptr         <= |grant ? gidx : ptr;
            busy        <= busy_n;
            in_flight   <= popcount(busy_n);
            err         <= err | beat_err;
            rsp_valid   <= (rsp_valid | rsp_set) & ~consume;
            for (int n = 0; n < N_REQ; n++) if (rsp_set[n]) rsp_data[n] <= core_dout_tdata;
            core_tvalid <= |grant;
            if (|grant) begin
                core_tdata <= req_data[gidx];
                core_tuser <= TAG_W'(gidx);
            end
        end
    end
endmodule

// File: tb/tb_cordic_arbiter.sv
// tb_cordic_arbiter: vector table, directed corner sequences and random traffic against a cycle-level reference model with an echoing core model.
module tb_cordic_arbiter;
    localparam int N   = 4;
    localparam int W   = 16;
    localparam int TW  = 4;
    localparam int LAT = 20;
    localparam int DW  = 2 * W;
    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [N-1:0]         req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N-1:0][DW-1:0] req_data, rsp_data;
    logic                 core_tvalid, core_dout_tvalid;
    logic [DW-1:0]        core_tdata, core_dout_tdata;
    logic [TW-1:0]        core_tuser, core_dout_tuser;
    logic [2:0]           in_flight;
    logic                 err;
    always #5 clk = ~clk;
    cordic_arbiter #(.N_REQ(N), .WIDTH(W), .TAG_W(TW), .CORE_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
        .core_tvalid(core_tvalid), .core_tdata(core_tdata), .core_tuser(core_tuser),
        .core_dout_tvalid(core_dout_tvalid), .core_dout_tdata(core_dout_tdata),
        .core_dout_tuser(core_dout_tuser), .in_flight(in_flight), .err(err)
    );
    int n_chk = 0, n_fail = 0, gc = 0;
    bit mv = 0, m_err, m_cv, echo = 1, lat_chk = 0;
    int mc, m_ptr, peak, samp_mc;
    logic [N-1:0]  m_busy, m_rspv, prev_rspv = '0, samp_ready;
    logic [DW-1:0] m_rspd [N];
    logic [DW-1:0] m_cd;
    logic [TW-1:0] m_cu;
    int hs [N];
    int dlog [$];
    logic          rv_ring [64];
    logic [DW-1:0] rd_ring [64];
    logic [TW-1:0] ru_ring [64];
    typedef struct {
        logic [N-1:0]  rv;
        logic [N-1:0]  ready;
        logic [2:0]    infl;
        logic          cv;
        logic [TW-1:0] cu;
    } vec_t;
    vec_t tbl [6];
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, gc);
        end
    endtask
    function automatic int model_grant();
        if (!(mv && mc > LAT)) return -1;
        for (int k = 1; k <= N; k++) begin
            int n;
            n = (m_ptr + k) % N;
            if (req_valid[n] && !m_busy[n]) return n;
        end
        return -1;
    endfunction
    task automatic tick();
        int g, t;
        logic [N-1:0] busy0, rspv0;
        if (echo) begin
            core_dout_tvalid = rv_ring[gc % 64];
            core_dout_tdata  = rd_ring[gc % 64];
            core_dout_tuser  = ru_ring[gc % 64];
        end
        rv_ring[gc % 64]         = 1'b0;
        rv_ring[(gc + LAT) % 64] = (core_tvalid === 1'b1);
        rd_ring[(gc + LAT) % 64] = core_tdata;
        ru_ring[(gc + LAT) % 64] = core_tuser;
        #1;
        g = model_grant();
        samp_ready = req_ready;
        samp_mc    = mc;
        if (mv) begin
            chk("req_ready", req_ready, (g < 0) ? 64'd0 : (64'd1 << g));
            chk("core_tvalid", core_tvalid, m_cv);
            if (m_cv) begin
                chk("core_tuser", core_tuser, m_cu);
                chk("core_tdata", core_tdata, m_cd);
            end
            chk("rsp_valid", rsp_valid, m_rspv);
            for (int n = 0; n < N; n++) if (m_rspv[n]) chk("rsp_data", rsp_data[n], m_rspd[n]);
            chk("in_flight", in_flight, $countones(m_busy));
            chk("err", err, m_err);
            if (lat_chk)
                for (int n = 0; n < N; n++)
                    if (rsp_valid[n] && !prev_rspv[n]) chk("rsp_latency", 64'(gc - hs[n]), 64'(LAT + 2));
            for (int n = 0; n < N; n++) if (req_ready[n] === 1'b1) dlog.push_back(n);
            if (int'(in_flight) > peak) peak = int'(in_flight);
        end
        prev_rspv = rsp_valid;
        if (rst) begin
            mv = 1; mc = 0; m_busy = '0; m_rspv = '0; m_ptr = N - 1; m_err = 0; m_cv = 0;
            for (int n = 0; n < N; n++) m_rspd[n] = '0;
        end else if (mv) begin
            busy0 = m_busy;
            rspv0 = m_rspv;
            m_cv  = (g >= 0);
            if (g >= 0) begin
                m_cd = req_data[g]; m_cu = TW'(g); m_busy[g] = 1'b1; m_ptr = g; hs[g] = gc;
            end
            for (int n = 0; n < N; n++)
                if (rspv0[n] && rsp_ready[n]) begin
                    m_rspv[n] = 1'b0;
                    m_busy[n] = 1'b0;
                end
            if (mc > LAT && core_dout_tvalid === 1'b1) begin
                t = int'(core_dout_tuser);
                if (t < N && busy0[t] && !rspv0[t]) begin
                    m_rspv[t] = 1'b1;
                    m_rspd[t] = core_dout_tdata;
                end else m_err = 1;
            end
            mc++;
        end
        @(posedge clk);
        #1;
        gc++;
        if (!echo) core_dout_tvalid = 1'b0;
    endtask
    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask
    task automatic inject(input logic [TW-1:0] tag, input logic [DW-1:0] d);
        core_dout_tvalid = 1'b1;
        core_dout_tuser  = tag;
        core_dout_tdata  = d;
        tick();
    endtask
    initial begin
        int n0;
        req_valid = '0; req_data = '0; rsp_ready = '0;
        core_dout_tvalid = 1'b0; core_dout_tdata = '0; core_dout_tuser = '0;
        for (int i = 0; i < 64; i++) rv_ring[i] = 1'b0;
        tbl = '{'{4'hf, 4'h1, 3'd0, 1'b0, 4'd0},
                '{4'hf, 4'h2, 3'd1, 1'b1, 4'd0},
                '{4'h9, 4'h8, 3'd2, 1'b1, 4'd1},
                '{4'hf, 4'h4, 3'd3, 1'b1, 4'd3},
                '{4'hf, 4'h0, 3'd4, 1'b1, 4'd2},
                '{4'h0, 4'h0, 3'd4, 1'b0, 4'd0}};
        @(posedge clk);
        #1;
        do_reset();
        chk("rst_core_tvalid", core_tvalid, 0);
        chk("rst_core_tdata", core_tdata, 0);
        chk("rst_core_tuser", core_tuser, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_in_flight", in_flight, 0);
        chk("rst_err", err, 0);
        req_valid = 4'hf; rsp_ready = 4'hf; lat_chk = 1;
        for (int n = 0; n < N; n++) req_data[n] = 32'hD000_0000 | n;
        dlog.delete();
        peak = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (samp_ready != '0) break;
        end
        chk("first_grant_cycle", samp_mc, LAT + 1);
        chk("first_grant", samp_ready, 4'h1);
        chk("first_issue_valid", core_tvalid, 1);
        chk("first_issue_tuser", core_tuser, 0);
        for (int i = 0; i < 120; i++) begin
            for (int n = 0; n < N; n++) req_data[n] = $urandom;
            tick();
        end
        chk("rr_grant_count", dlog.size() >= 16, 1);
        for (int i = 0; i < 16 && i < dlog.size(); i++) chk("rr_order", dlog[i], i % N);
        chk("in_flight_peak", peak, 4);
        echo = 0; lat_chk = 0; core_dout_tvalid = 1'b0;
        req_valid = '0; rsp_ready = '0;
        for (int n = 0; n < N; n++) req_data[n] = 32'hC0DE_0000 | n;
        do_reset();
        repeat (LAT + 1) tick();
        for (int i = 0; i < 6; i++) begin
            req_valid = tbl[i].rv;
            #1;
            chk("tbl_ready", req_ready, tbl[i].ready);
            chk("tbl_in_flight", in_flight, tbl[i].infl);
            chk("tbl_core_tvalid", core_tvalid, tbl[i].cv);
            if (tbl[i].cv) chk("tbl_core_tuser", core_tuser, tbl[i].cu);
            tick();
        end
        inject(4'd3, 32'h3333_AAAA);
        inject(4'd1, 32'h1111_BBBB);
        chk("ooo_rsp3", rsp_data[3], 32'h3333_AAAA);
        chk("ooo_rsp1", rsp_data[1], 32'h1111_BBBB);
        chk("ooo_valid", rsp_valid, 4'b1010);
        chk("ooo_err", err, 0);
        rsp_ready = 4'b1010;
        tick();
        rsp_ready = '0;
        inject(4'd1, 32'hDEAD_0001);
        chk("err_not_busy", err, 1);
        chk("err_not_busy_rsp", rsp_valid, 0);
        do_reset();
        repeat (10) tick();
        inject(4'd5, 32'hDEAD_0005);
        repeat (LAT - 10) tick();
        chk("drain_drop_err", err, 0);
        inject(4'd5, 32'hDEAD_0005);
        chk("err_bad_tag", err, 1);
        chk("err_bad_tag_rsp", rsp_valid, 0);
        do_reset();
        repeat (LAT + 1) tick();
        req_valid = 4'h1;
        tick();
        req_valid = '0;
        inject(4'd0, 32'hAAAA_0000);
        inject(4'd0, 32'hBBBB_0000);
        chk("err_dup_data", rsp_data[0], 32'hAAAA_0000);
        chk("err_dup", err, 1);
        echo = 1; lat_chk = 1;
        req_valid = 4'b0100; req_data[2] = 32'h1234_5678; rsp_ready = '0;
        do_reset();
        repeat (LAT + 1) tick();
        repeat (30) tick();
        chk("credit_rsp_valid", rsp_valid[2], 1);
        chk("credit_rsp_data", rsp_data[2], 32'h1234_5678);
        chk("credit_ready_held", req_ready[2], 0);
        rsp_ready = 4'b0100;
        #1;
        chk("credit_ready_consume_cycle", req_ready[2], 0);
        tick();
        rsp_ready = '0;
        #1;
        chk("credit_regrant", req_ready, 4'b0100);
        tick();
        rsp_ready = 4'hf; req_valid = 4'b0111;
        repeat (3) tick();
        chk("mid_pre_in_flight", in_flight, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rsp_valid", rsp_valid, 0);
        chk("mid_in_flight", in_flight, 0);
        repeat (LAT + 1) tick();
        chk("mid_err", err, 0);
        n0 = dlog.size();
        repeat (60) tick();
        chk("mid_resume", dlog.size() > n0, 1);
        do_reset();
        for (int i = 0; i < 800; i++) begin
            req_valid = 4'($urandom);
            rsp_ready = 4'($urandom) | 4'($urandom);
            for (int n = 0; n < N; n++) req_data[n] = $urandom;
            tick();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
